// File: rtl/cpu_pkg.sv
// Shared types and widths for the fetch front end.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 11;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned PC_W     = 64;

  typedef enum logic [1:0] {FETCH, WAIT, DROP} fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instr, pc}; entry 0 is always the head, so pop shifts entry 1 down.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok, push_ok;

  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  always_comb begin
    count_d = count_q;
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) mem0_d = push_data;
          else                 mem1_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          mem0_d  = mem1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            mem0_d = push_data;
          end else begin
            mem0_d = mem1_q;
            mem1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
      mem0_q  <= '0;
      mem1_q  <= '0;
    end else begin
      count_q <= count_d;
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
    end
  end

  assign count = count_q;
  assign head  = mem0_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues one outstanding imem read at a time,
// buffers responses in a 2-entry queue and redirects on taken branches.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [INSTR_W-1:0]  dec_instr,
  output logic [OPCODE_W-1:0] dec_opcode,
  output logic [PC_W-1:0]     dec_pc,
  input  logic                br_valid,
  input  logic                br_taken,
  input  logic                br_uncond,
  input  logic [PC_W-1:0]     br_pc,
  input  logic [INSTR_W-1:0]  br_instr
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic            started_q;
  logic [1:0]      q_count;
  fetch_entry_t    q_head;
  logic            push, pop, flush, redirect, granted;
  logic [PC_W-1:0] br_off, target;
  logic            unused_br_bits;

  assign unused_br_bits = ^br_instr[31:26];

  assign br_off   = br_uncond ? {{36{br_instr[25]}}, br_instr[25:0], 2'b00}
                              : {{43{br_instr[23]}}, br_instr[23:5], 2'b00};
  assign target   = br_pc + br_off;
  assign redirect = br_valid && br_taken;

  // started_q keeps req low during reset and until the first edge after release.
  assign imem_req  = started_q && (state_q == FETCH) && (q_count != 2'd2);
  assign imem_addr = pc_q;
  assign granted   = imem_req && imem_gnt;

  assign dec_valid  = (q_count != 2'd0);
  assign dec_instr  = q_head.instr;
  assign dec_pc     = q_head.pc;
  assign dec_opcode = q_head.instr[31:21];
  assign pop        = dec_valid && dec_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (granted) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (redirect) begin
      pc_d  = target;
      flush = 1'b1;
      push  = 1'b0;
      // A request granted this cycle or still outstanding is wrong-path.
      if (state_q == FETCH) state_d = granted ? DROP : FETCH;
      else                  state_d = imem_rvalid ? FETCH : DROP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      started_q <= 1'b1;
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ('{instr: imem_rdata, pc: req_pc_q}),
    .pop       (pop),
    .flush     (flush),
    .count     (q_count),
    .head      (q_head)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an always-grant memory model and adjustable response delay.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [10:0] dec_opcode;
  logic [63:0] dec_pc;
  logic        br_valid;
  logic        br_taken;
  logic        br_uncond;
  logic [63:0] br_pc;
  logic [31:0] br_instr;

  int checks = 0;
  int errors = 0;
  int extra_delay = 0;

  logic        pend;
  int          cnt;
  logic [63:0] pend_addr;

  instr_fetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_opcode  (dec_opcode),
    .dec_pc      (dec_pc),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_uncond   (br_uncond),
    .br_pc       (br_pc),
    .br_instr    (br_instr)
  );

  always #5 clk = ~clk;

  // Word at addr 0 is 32'h8B000000; low bits tag the address.
  function automatic logic [31:0] memf(input logic [63:0] a);
    return {11'h458, a[22:2]};
  endfunction

  assign imem_gnt = imem_req;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
      pend        <= 1'b0;
      cnt         <= 0;
      pend_addr   <= 64'h0;
    end else begin
      imem_rvalid <= 1'b0;
      if (imem_req && imem_gnt) begin
        if (extra_delay == 0) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= memf(imem_addr);
        end else begin
          pend      <= 1'b1;
          cnt       <= extra_delay - 1;
          pend_addr <= imem_addr;
        end
      end else if (pend) begin
        if (cnt == 0) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= memf(pend_addr);
          pend        <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    dec_ready   = 1'b0;
    br_valid    = 1'b0;
    br_taken    = 1'b0;
    br_uncond   = 1'b0;
    br_pc       = 64'h0;
    br_instr    = 32'h0;
    extra_delay = 0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dec_ready = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    br_uncond = 1'b0; br_pc = 64'h0; br_instr = 32'h0;
    #2;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0h want 0", imem_req); end
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL rst_addr: got %0h want 0", imem_addr); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h want 0", dec_valid); end
    checks++; if (dec_instr !== 32'h0 || dec_opcode !== 11'h0 || dec_pc !== 64'h0) begin
      errors++; $display("FAIL rst_dec: got %0h/%0h/%0h want 0/0/0", dec_instr, dec_opcode, dec_pc);
    end
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req_held: got %0h want 0", imem_req); end
  endtask

  task automatic test_stream();
    int first_req = -1, first_rv = -1, first_dv = -1, nreq = 0, npop = 0, pop0 = 0, pop1 = 0;
    logic [63:0] a [3];
    logic [63:0] exp_pc;
    do_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (imem_req) begin
        if (nreq < 3) a[nreq] = imem_addr;
        if (first_req < 0) first_req = i;
        nreq++;
      end
      if (imem_rvalid && first_rv < 0) first_rv = i;
      if (dec_valid) begin
        if (first_dv < 0) first_dv = i;
        exp_pc = 64'(npop * 4);
        checks++; if (dec_pc !== exp_pc || dec_instr !== memf(exp_pc)) begin
          errors++; $display("FAIL stream_pop%0d: got pc %0h instr %0h want pc %0h instr %0h",
                             npop, dec_pc, dec_instr, exp_pc, memf(exp_pc));
        end
        if (npop == 0) begin
          pop0 = i;
          checks++; if (dec_opcode !== 11'b10001011000) begin
            errors++; $display("FAIL stream_opcode: got %0h want 458", dec_opcode);
          end
        end
        if (npop == 1) pop1 = i;
        npop++;
      end
    end
    checks++; if (first_req !== 0) begin errors++; $display("FAIL first_req_cycle: got %0d want 0", first_req); end
    checks++; if (nreq < 3 || a[0] !== 64'h0 || a[1] !== 64'h4 || a[2] !== 64'h8) begin
      errors++; $display("FAIL addr_seq: got %0d reqs %0h %0h %0h want 0 4 8", nreq, a[0], a[1], a[2]);
    end
    checks++; if (first_rv < 0 || first_dv !== first_rv + 1) begin
      errors++; $display("FAIL rv_to_valid: got rvalid@%0d valid@%0d want valid one later", first_rv, first_dv);
    end
    checks++; if (npop < 2 || pop1 - pop0 !== 2) begin
      errors++; $display("FAIL throughput: got %0d pops spacing %0d want spacing 2", npop, pop1 - pop0);
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      if (imem_req) nreq++;
    end
    checks++; if (nreq !== 2) begin errors++; $display("FAIL bp_reqs: got %0d want 2", nreq); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %0h want 0", imem_req); end
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 64'h0 || dec_opcode !== 11'h458) begin
      errors++; $display("FAIL bp_head: got v%0h pc %0h op %0h want v1 pc 0 op 458", dec_valid, dec_pc, dec_opcode);
    end
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 64'h4) begin
      errors++; $display("FAIL bp_second: got v%0h pc %0h want v1 pc 4", dec_valid, dec_pc);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h8) begin
      errors++; $display("FAIL bp_resume: got req %0h addr %0h want req 1 addr 8", imem_req, imem_addr);
    end
  endtask

  task automatic test_uncond_branch();
    do_reset();
    repeat (8) step();
    br_valid = 1'b1; br_taken = 1'b1; br_uncond = 1'b1;
    br_pc = 64'h40; br_instr = {6'b000101, 26'h3FFFFFE};
    step();
    br_valid = 1'b0; br_taken = 1'b0;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL ub_flush: got %0h want 0", dec_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h38) begin
      errors++; $display("FAIL ub_target: got req %0h addr %0h want req 1 addr 38", imem_req, imem_addr);
    end
    step(); step();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 64'h38 || dec_instr !== memf(64'h38)) begin
      errors++; $display("FAIL ub_land: got v%0h pc %0h instr %0h want v1 pc 38 instr %0h",
                         dec_valid, dec_pc, dec_instr, memf(64'h38));
    end
  endtask

  task automatic test_cond_branch();
    do_reset();
    repeat (8) step();
    br_valid = 1'b1; br_taken = 1'b0; br_uncond = 1'b0;
    br_pc = 64'h100; br_instr = 32'h540000A0;
    step();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 64'h0 || imem_req !== 1'b0 || imem_addr !== 64'h8) begin
      errors++; $display("FAIL cb_not_taken: got v%0h pc %0h req %0h addr %0h want v1 pc 0 req 0 addr 8",
                         dec_valid, dec_pc, imem_req, imem_addr);
    end
    br_taken = 1'b1;
    step();
    br_valid = 1'b0; br_taken = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h114 || dec_valid !== 1'b0) begin
      errors++; $display("FAIL cb_taken: got req %0h addr %0h v%0h want req 1 addr 114 v0",
                         imem_req, imem_addr, dec_valid);
    end
  endtask

  task automatic test_redirect_on_grant();
    do_reset();
    dec_ready = 1'b1;
    step();
    br_valid = 1'b1; br_taken = 1'b1; br_uncond = 1'b1;
    br_pc = 64'h200; br_instr = {6'b000101, 26'd4};
    step();
    br_valid = 1'b0; br_taken = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rg_drop: got req %0h want 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h210 || dec_valid !== 1'b0) begin
      errors++; $display("FAIL rg_target: got req %0h addr %0h v%0h want req 1 addr 210 v0",
                         imem_req, imem_addr, dec_valid);
    end
  endtask

  task automatic test_drop_delayed();
    int n = 0;
    bit got_req = 0, saw_rv = 0, saw_dv = 0;
    do_reset();
    dec_ready = 1'b1;
    extra_delay = 3;
    step();
    step();
    br_valid = 1'b1; br_taken = 1'b1; br_uncond = 1'b1;
    br_pc = 64'h40; br_instr = {6'b000101, 26'h3FFFFFE};
    step();
    br_valid = 1'b0; br_taken = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL dd_req_low: got %0h want 0", imem_req); end
    for (int i = 0; i < 10 && !got_req; i++) begin
      step();
      n++;
      if (imem_rvalid) saw_rv = 1;
      if (dec_valid) saw_dv = 1;
      if (imem_req) got_req = 1;
    end
    checks++; if (!got_req || n !== 3) begin
      errors++; $display("FAIL dd_drop_len: got req %0d after %0d cycles want req after 3", got_req, n);
    end
    checks++; if (!saw_rv || saw_dv) begin
      errors++; $display("FAIL dd_discard: got rvalid %0d dec_valid %0d want 1 0", saw_rv, saw_dv);
    end
    checks++; if (imem_addr !== 64'h38) begin errors++; $display("FAIL dd_target: got %0h want 38", imem_addr); end
    extra_delay = 0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    repeat (3) step();
    checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL rw_prefill: got %0h want 1", dec_valid); end
    extra_delay = 3;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_in_wait: got req %0h want 0", imem_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 64'h0 || dec_valid !== 1'b0) begin
      errors++; $display("FAIL rw_async: got req %0h addr %0h v%0h want 0 0 0", imem_req, imem_addr, dec_valid);
    end
    checks++; if (dec_instr !== 32'h0 || dec_opcode !== 11'h0 || dec_pc !== 64'h0) begin
      errors++; $display("FAIL rw_dec: got %0h/%0h/%0h want 0/0/0", dec_instr, dec_opcode, dec_pc);
    end
    #3;
    reset_n = 1'b1;
    extra_delay = 0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0 || dec_valid !== 1'b0) begin
      errors++; $display("FAIL rw_restart: got req %0h addr %0h v%0h want 1 0 0", imem_req, imem_addr, dec_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_uncond_branch();
    test_cond_branch();
    test_redirect_on_grant();
    test_drop_delayed();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
